// File: rtl/slink_rx_train_ctrl.sv
// ---------------------------------------------------------------------------
// SlinkRxTrainCtrl : receive-side link training sequencer.
//
// Walks the RX lanes through block alignment, TS1/TS2/SDS detection and into
// ACTIVE. A wait that takes too long triggers a retry, with a bounded number
// of retries before the block parks in ERROR.
//
// Ports
//   clk           : single clock
//   reset         : asynchronous active-high reset (release synchronised here)
//   start         : level request to train; low returns the FSM to IDLE
//   active_lanes  : log2 of the required lane count (clamped to NUM_LANES)
//   rx_ts1_seen   : per-lane TS1 detect from the deskew datapath
//   rx_ts2_seen   : per-lane TS2 detect
//   rx_sds_seen   : per-lane SDS detect
//   align_enable  : enable to the align/deskew datapath
//   blockalign    : block-align search request (high throughout ALIGN)
//   train_state   : encoded FSM state
//   link_trained  : high only in ACTIVE
//   train_error   : high only in ERROR
//   retry_count   : retries taken in the current attempt
// ---------------------------------------------------------------------------
module slink_rx_train_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int BA_CYCLES      = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 3,
    localparam int RW            = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           active_lanes,
    input  logic [NUM_LANES-1:0] rx_ts1_seen,
    input  logic [NUM_LANES-1:0] rx_ts2_seen,
    input  logic [NUM_LANES-1:0] rx_sds_seen,
    output logic                 align_enable,
    output logic                 blockalign,
    output logic [2:0]           train_state,
    output logic                 link_trained,
    output logic                 train_error,
    output logic [RW-1:0]        retry_count
);

    localparam int RETRY_CYCLES = 4;
    localparam int CNT_MAX0     = (BA_CYCLES > TIMEOUT_CYCLES) ? BA_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX      = (CNT_MAX0 > RETRY_CYCLES) ? CNT_MAX0 : RETRY_CYCLES;
    localparam int CW           = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BA_LAST      = CW'(BA_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RETRY_LAST   = CW'(RETRY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_WAIT_TS1 = 3'd2,
        ST_WAIT_TS2 = 3'd3,
        ST_WAIT_SDS = 3'd4,
        ST_ACTIVE   = 3'd5,
        ST_RETRY    = 3'd6,
        ST_ERROR    = 3'd7
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [1:0]             sync_q;
    logic                   rstHold;
    logic                   timeoutHit;
    logic                   ts1AllSeen, ts2AllSeen, sdsAllSeen;

    // Two-flop release synchroniser: assertion is immediate, release is seen
    // by the FSM only after two clean edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rstHold = sync_q[1];

    // Lane i is required when i < 2**active_lanes; lanes past NUM_LANES simply
    // do not exist, which gives the clamp for free.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mask_d[i] = (i < (1 << active_lanes));
        end
    end

    assign ts1AllSeen = ((rx_ts1_seen & mask_q) == mask_q);
    assign ts2AllSeen = ((rx_ts2_seen & mask_q) == mask_q);
    assign sdsAllSeen = ((rx_sds_seen & mask_q) == mask_q);

    // State register. The lane mask is registered so a change of
    // active_lanes lands one cycle later and never moves the FSM by itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            mask_q  <= '1;
        end else begin
            mask_q <= mask_d;
            if (rstHold) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                retry_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                retry_q <= retry_d;
            end
        end
    end

    // Next-state logic. In the wait states the exit condition is checked
    // before the timeout, so an exit on the last allowed cycle still wins.
    always_comb begin
        state_d    = state_q;
        timeoutHit = 1'b0;
        case (state_q)
            ST_IDLE:     state_d = ST_ALIGN;
            ST_ALIGN:    if (cnt_q == BA_LAST) state_d = ST_WAIT_TS1;
            ST_WAIT_TS1: begin
                if (ts1AllSeen)                  state_d    = ST_WAIT_TS2;
                else if (cnt_q == TIMEOUT_LAST)  timeoutHit = 1'b1;
            end
            ST_WAIT_TS2: begin
                if (ts2AllSeen)                  state_d    = ST_WAIT_SDS;
                else if (cnt_q == TIMEOUT_LAST)  timeoutHit = 1'b1;
            end
            ST_WAIT_SDS: begin
                if (sdsAllSeen)                  state_d    = ST_ACTIVE;
                else if (cnt_q == TIMEOUT_LAST)  timeoutHit = 1'b1;
            end
            ST_RETRY:    if (cnt_q == RETRY_LAST) state_d = ST_ALIGN;
            ST_ACTIVE:   state_d = ST_ACTIVE;
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_IDLE;
        endcase

        if (timeoutHit) begin
            state_d = (retry_q < RETRY_LIMIT) ? ST_RETRY : ST_ERROR;
        end

        if (!start) begin
            state_d = ST_IDLE;
        end

        // Any stay in IDLE (or entry to it) starts the next attempt from zero.
        retry_d = retry_q;
        if ((state_d == ST_IDLE) || (state_q == ST_IDLE)) begin
            retry_d = '0;
        end else if (timeoutHit && (retry_q < RETRY_LIMIT)) begin
            retry_d = retry_q + 1'b1;
        end

        // One shared wait counter, cleared on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {ST_ALIGN, ST_WAIT_TS1, ST_WAIT_TS2,
                                     ST_WAIT_SDS, ST_RETRY}) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        align_enable = 1'b0;
        blockalign   = 1'b0;
        link_trained = 1'b0;
        train_error  = 1'b0;
        case (state_q)
            ST_ALIGN: begin
                align_enable = 1'b1;
                blockalign   = 1'b1;
            end
            ST_WAIT_TS1, ST_WAIT_TS2, ST_WAIT_SDS: align_enable = 1'b1;
            ST_ACTIVE: begin
                align_enable = 1'b1;
                link_trained = 1'b1;
            end
            ST_ERROR:  train_error = 1'b1;
            default:   align_enable = 1'b0;
        endcase
    end

    assign train_state = state_q;
    assign retry_count = retry_q;

endmodule
